// File: rtl/color_point_finder.sv
`default_nettype none
// ============================================================================
//  Module   : color_point_finder
//  Purpose  : Classifies Y/Cr/Cb pixels into four marker colours, tracks frame
//             coordinates and emits run-filtered points plus end-of-frame.
//  Revision : 1.0 - initial release
// ============================================================================
module color_point_finder #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int RUN_MIN  = 3,
    parameter int Y_MIN    = 32,
    parameter int TOL      = 16,
    parameter int CR0      = 200,
    parameter int CB0      = 100,
    parameter int CR1      = 100,
    parameter int CB1      = 200,
    parameter int CR2      = 60,
    parameter int CB2      = 60,
    parameter int CR3      = 180,
    parameter int CB3      = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       pixel_valid,
    input  logic [7:0] pixel_y,
    input  logic [7:0] pixel_cr,
    input  logic [7:0] pixel_cb,
    output logic [1:0] color,
    output logic [9:0] interesting_x,
    output logic [8:0] interesting_y,
    output logic       interesting_flag,
    output logic       frame_flag
);

    localparam int                  c_RUN_W   = $clog2(RUN_MIN + 1);
    localparam logic [c_RUN_W-1:0]  c_RUN_MIN = c_RUN_W'(RUN_MIN);
    localparam logic [c_RUN_W-1:0]  c_RUN_ONE = c_RUN_W'(1);
    localparam logic [9:0]          c_X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [8:0]          c_Y_LAST  = 9'(V_ACTIVE - 1);
    localparam logic [7:0]          c_Y_MIN   = 8'(Y_MIN);
    localparam logic signed [8:0]   c_TOL     = 9'(TOL);
    localparam int                  c_CR [4]  = '{CR0, CR1, CR2, CR3};
    localparam int                  c_CB [4]  = '{CB0, CB1, CB2, CB3};

    logic [3:0] w_hit;
    logic       w_match;
    logic [1:0] w_class;

    // Chroma distances are taken as 9-bit signed values so they never wrap.
    generate
        for (genvar g = 0; g < 4; g++) begin : g_class
            logic signed [8:0] w_dcr;
            logic signed [8:0] w_dcb;
            assign w_dcr = $signed({1'b0, pixel_cr}) - $signed(9'(c_CR[g]));
            assign w_dcb = $signed({1'b0, pixel_cb}) - $signed(9'(c_CB[g]));
            assign w_hit[g] = (pixel_y >= c_Y_MIN)
                            && (w_dcr >= -c_TOL) && (w_dcr <= c_TOL)
                            && (w_dcb >= -c_TOL) && (w_dcb <= c_TOL);
        end
    endgenerate

    always_comb begin
        w_class = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_hit[i]) w_class = 2'(i);
        end
    end
    assign w_match = |w_hit;

    // ---------------- stage 1: coordinates and classification -------------
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic [9:0] w_x_cur;
    logic [8:0] w_y_cur;
    logic       w_eol;
    logic       w_eof;
    logic       r_s1_valid;
    logic       r_s1_match;
    logic [1:0] r_s1_class;
    logic [9:0] r_s1_x;
    logic [8:0] r_s1_y;
    logic       r_s1_eof;

    assign w_x_cur = vsync ? 10'd0 : r_x;
    assign w_y_cur = vsync ? 9'd0  : r_y;
    assign w_eol   = (w_x_cur == c_X_LAST);
    assign w_eof   = w_eol && (w_y_cur == c_Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_match <= 1'b0;
            r_s1_class <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_eof   <= 1'b0;
        end else begin
            r_s1_valid <= pixel_valid;
            if (pixel_valid) begin
                r_s1_match <= w_match;
                r_s1_class <= w_class;
                r_s1_x     <= w_x_cur;
                r_s1_y     <= w_y_cur;
                r_s1_eof   <= w_eof;
                r_x        <= w_eol ? 10'd0 : w_x_cur + 10'd1;
                r_y        <= w_eof ? 9'd0 : (w_eol ? w_y_cur + 9'd1 : w_y_cur);
            end else if (vsync) begin
                r_x <= '0;
                r_y <= '0;
            end
        end
    end

    // ---------------- stage 2: run filter and outputs ---------------------
    // A vsync always lands the next pixel on x==0, which restarts the run,
    // so frame starts need no separate run-clear path.
    logic [1:0]         r_run_class;
    logic [c_RUN_W-1:0] r_run_len;
    logic [c_RUN_W-1:0] w_len_next;
    logic               w_start;
    logic               w_emit;

    always_comb begin
        w_start    = (r_s1_x == 10'd0) || (r_s1_class != r_run_class) || (r_run_len == '0);
        w_len_next = r_run_len;
        if (!r_s1_match) begin
            w_len_next = '0;
        end else if (w_start) begin
            w_len_next = c_RUN_ONE;
        end else if (r_run_len != c_RUN_MIN) begin
            w_len_next = r_run_len + c_RUN_ONE;
        end
        w_emit = r_s1_valid && r_s1_match && (w_len_next == c_RUN_MIN)
               && (w_start || (r_run_len != c_RUN_MIN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_class      <= '0;
            r_run_len        <= '0;
            color            <= '0;
            interesting_x    <= '0;
            interesting_y    <= '0;
            interesting_flag <= 1'b0;
            frame_flag       <= 1'b0;
        end else begin
            interesting_flag <= w_emit;
            frame_flag       <= r_s1_valid && r_s1_eof;
            if (r_s1_valid) begin
                r_run_len   <= w_len_next;
                r_run_class <= r_s1_class;
            end
            if (w_emit) begin
                color         <= r_s1_class;
                interesting_x <= r_s1_x;
                interesting_y <= r_s1_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_color_point_finder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_color_point_finder
//  Purpose  : Self-checking bench for color_point_finder (small frame size).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_color_point_finder;

    localparam int c_H    = 32;
    localparam int c_V    = 8;
    localparam int c_RUN  = 3;
    localparam int c_YMIN = 32;
    localparam int c_TOL  = 16;
    // Class 2 is moved next to class 0 so their windows overlap.
    localparam int c_CRS [4] = '{200, 100, 180, 180};
    localparam int c_CBS [4] = '{100, 200, 100, 180};

    logic       clk = 1'b0;
    logic       reset, vsync, pixel_valid;
    logic [7:0] pixel_y, pixel_cr, pixel_cb;
    logic [1:0] color;
    logic [9:0] interesting_x;
    logic [8:0] interesting_y;
    logic       interesting_flag, frame_flag;
    logic [22:0] act, expv;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_x, m_y, m_cls, m_len;
    bit p_flag, p_ff;
    int p_col, p_x, p_y;

    color_point_finder #(
        .H_ACTIVE(c_H), .V_ACTIVE(c_V), .RUN_MIN(c_RUN), .Y_MIN(c_YMIN), .TOL(c_TOL),
        .CR0(c_CRS[0]), .CB0(c_CBS[0]), .CR1(c_CRS[1]), .CB1(c_CBS[1]),
        .CR2(c_CRS[2]), .CB2(c_CBS[2]), .CR3(c_CRS[3]), .CB3(c_CBS[3])
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .pixel_valid(pixel_valid),
        .pixel_y(pixel_y), .pixel_cr(pixel_cr), .pixel_cb(pixel_cb),
        .color(color), .interesting_x(interesting_x), .interesting_y(interesting_y),
        .interesting_flag(interesting_flag), .frame_flag(frame_flag)
    );

    always #5 clk = ~clk;

    assign act = {interesting_flag, frame_flag, color, interesting_x, interesting_y};

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int classify(input int yy, input int cr, input int cb);
        if (yy < c_YMIN) return -1;
        for (int i = 0; i < 4; i++) begin
            if (iabs(cr - c_CRS[i]) <= c_TOL && iabs(cb - c_CBS[i]) <= c_TOL) return i;
        end
        return -1;
    endfunction

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Drive one cycle, advance the model across the edge, sample 1 ns later.
    task automatic step(input bit rs, input bit vs, input bit pv,
                        input int yy, input int cr, input int cb);
        int c;
        reset = rs; vsync = vs; pixel_valid = pv;
        pixel_y = 8'(yy); pixel_cr = 8'(cr); pixel_cb = 8'(cb);
        @(posedge clk);
        if (rs) begin
            expv = '0;
            p_flag = 0; p_ff = 0;
            m_x = 0; m_y = 0; m_len = 0; m_cls = -1;
        end else begin
            expv[22] = p_flag;
            expv[21] = p_ff;
            if (p_flag) expv[20:0] = {2'(p_col), 10'(p_x), 9'(p_y)};
            p_flag = 0; p_ff = 0;
            if (vs) begin m_x = 0; m_y = 0; m_len = 0; end
            if (pv) begin
                c = classify(yy, cr, cb);
                if (c < 0) begin
                    m_len = 0;
                end else if (m_x == 0 || c != m_cls || m_len == 0) begin
                    m_cls = c; m_len = 1; p_flag = (c_RUN == 1);
                end else if (m_len < c_RUN) begin
                    m_len++; p_flag = (m_len == c_RUN);
                end
                p_col = c; p_x = m_x; p_y = m_y;
                p_ff = (m_x == c_H - 1) && (m_y == c_V - 1);
                if (m_x == c_H - 1) begin
                    m_x = 0;
                    m_y = (m_y == c_V - 1) ? 0 : m_y + 1;
                end else begin
                    m_x++;
                end
            end
        end
        #1;
    endtask

    // k < 0: no-match pixel; otherwise the centre of class k.
    task automatic px(input bit vs, input int k);
        if (k < 0) step(1'b0, vs, 1'b1, 10, 0, 0);
        else       step(1'b0, vs, 1'b1, 128, c_CRS[k], c_CBS[k]);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 2 || i == 5 || i == 6) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
            else if (i < 5)                px(1'b0, 1);
            else                           idle();
            if (act !== expv) begin
                bad++; $display("FAIL reset step %0d: got %h want %h", i, act, expv);
            end
            total++;
            if (i >= 5 && act !== 23'd0) begin
                bad++; $display("FAIL reset_zero step %0d: got %h want 0", i, act);
            end
            if (i >= 5) total++;
        end
    endtask

    task automatic test_run_basic();
        int n = 0, sidx = -1, sx = -1, sy = -1, sc = -1;
        for (int i = 0; i < 23; i++) begin
            if (i < 21) px(i == 0, (i >= 10) ? 1 : -1);
            else        idle();
            if (act !== expv) begin
                bad++; $display("FAIL run_basic step %0d: got %h want %h", i, act, expv);
            end
            total++;
            if (interesting_flag) begin
                n++; sidx = i; sx = interesting_x; sy = interesting_y; sc = color;
            end
        end
        if (n !== 1 || sidx !== 13 || sx !== 12 || sy !== 0 || sc !== 1) begin
            bad++;
            $display("FAIL run_basic_strobe: got n=%0d idx=%0d x=%0d y=%0d c=%0d want 1 13 12 0 1",
                     n, sidx, sx, sy, sc);
        end
        total++;
    endtask

    task automatic test_alternate();
        int n = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) px(i == 0, (i % 2) ? 2 : 0);
            else        idle();
            if (act !== expv) begin
                bad++; $display("FAIL alternate step %0d: got %h want %h", i, act, expv);
            end
            total++;
            if (interesting_flag) n++;
        end
        if (n !== 0) begin
            bad++; $display("FAIL alternate_count: got %0d want 0", n);
        end
        total++;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0 && i < 5) px(1'b0, 3);
            else                     idle();
            if (act !== expv) begin
                bad++; $display("FAIL gap_run step %0d: got %h want %h", i, act, expv);
            end
            total++;
            if (interesting_flag && color == 2'd3) n++;
        end
        if (n !== 1) begin
            bad++; $display("FAIL gap_run_count: got %0d want 1", n);
        end
        total++;
    endtask

    task automatic test_line_break();
        int n = 0;
        int npre = 6 * c_H - 2;
        for (int i = 0; i < npre + 6; i++) begin
            if (i < npre)          px(i == 0, -1);
            else if (i < npre + 3) px(1'b0, 0);
            else                   idle();
            if (act !== expv) begin
                bad++; $display("FAIL line_break step %0d: got %h want %h", i, act, expv);
            end
            total++;
            if (interesting_flag) n++;
        end
        if (n !== 0) begin
            bad++; $display("FAIL line_break_count: got %0d want 0", n);
        end
        total++;
    endtask

    task automatic test_frame();
        int nff = 0, nint = 0, fidx = -1;
        int n0, rem;
        for (int i = 0; i < c_H * c_V + 3; i++) begin
            if (i < c_H * c_V) px(i == 0, -1);
            else               idle();
            if (act !== expv) begin
                bad++; $display("FAIL frame step %0d: got %h want %h", i, act, expv);
            end
            total++;
            if (frame_flag) begin nff++; fidx = i; end
            if (interesting_flag) nint++;
        end
        if (nff !== 1 || fidx !== c_H * c_V || nint !== 0) begin
            bad++; $display("FAIL frame_flag: got n=%0d idx=%0d int=%0d want 1 %0d 0",
                            nff, fidx, nint, c_H * c_V);
        end
        total++;
        // abandon a frame part way through with a vsync
        nff = 0; nint = 0;
        n0 = (c_V / 2) * c_H + c_H / 2;
        rem = c_H * c_V - n0;
        for (int i = 0; i < n0 + rem + 2; i++) begin
            if (i < n0)          px(i == 0, -1);
            else if (i == n0)    px(1'b1, 1);
            else if (i < n0 + 3) px(1'b0, 1);
            else                 px(1'b0, -1);
            if (act !== expv) begin
                bad++; $display("FAIL vsync_abort step %0d: got %h want %h", i, act, expv);
            end
            total++;
            if (frame_flag) nff++;
            if (interesting_flag) begin
                nint++;
                if (interesting_x !== 10'd2 || interesting_y !== 9'd0) begin
                    bad++; $display("FAIL vsync_origin: got x=%0d y=%0d want 2 0",
                                    interesting_x, interesting_y);
                end
                total++;
            end
        end
        if (nff !== 0 || nint !== 1) begin
            bad++; $display("FAIL vsync_abort_count: got ff=%0d int=%0d want 0 1", nff, nint);
        end
        total++;
    endtask

    task automatic test_boundaries();
        int by  [4] = '{128, c_YMIN - 1, 128, 128};
        int bcr [4] = '{190, 100, c_CRS[0] + c_TOL, c_CRS[0] + c_TOL + 1};
        int bcb [4] = '{100, 200, 100, 100};
        int bn  [4] = '{1, 0, 1, 0};
        int n, sc;
        for (int k = 0; k < 4; k++) begin
            n = 0; sc = -1;
            for (int i = 0; i < 6; i++) begin
                if (i == 0)     px(1'b1, -1);
                else if (i < 4) step(1'b0, 1'b0, 1'b1, by[k], bcr[k], bcb[k]);
                else            idle();
                if (act !== expv) begin
                    bad++; $display("FAIL boundary%0d step %0d: got %h want %h", k, i, act, expv);
                end
                total++;
                if (interesting_flag) begin n++; sc = color; end
            end
            if (n !== bn[k] || (bn[k] == 1 && sc !== 0)) begin
                bad++; $display("FAIL boundary%0d_result: got n=%0d color=%0d want n=%0d color=0",
                                k, n, sc, bn[k]);
            end
            total++;
        end
    endtask

    task automatic test_random();
        int k = 0;
        int yy, cr, cb;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) k = $urandom_range(0, 3);
            yy = $urandom_range(20, 255);
            if ($urandom_range(0, 9) < 8) begin
                cr = clamp8(c_CRS[k] + int'($urandom_range(0, 40)) - 20);
                cb = clamp8(c_CBS[k] + int'($urandom_range(0, 40)) - 20);
            end else begin
                cr = $urandom_range(0, 255);
                cb = $urandom_range(0, 255);
            end
            step($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0, yy, cr, cb);
            if (act !== expv) begin
                bad++; $display("FAIL random step %0d: got %h want %h", i, act, expv);
            end
            total++;
        end
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b0; pixel_valid = 1'b0;
        pixel_y = '0; pixel_cr = '0; pixel_cb = '0;
        expv = '0;
        m_x = 0; m_y = 0; m_cls = -1; m_len = 0;
        p_flag = 0; p_ff = 0; p_col = 0; p_x = 0; p_y = 0;
        test_reset();
        test_run_basic();
        test_alternate();
        test_line_break();
        test_frame();
        test_boundaries();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
